// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX/RX datapath and the TX arbiter.
// Holds no logic; import with uart_pkg::*.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from ptr with wrap.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [IW:0] idx;

    // Walk offsets from farthest to nearest so the closest set bit to ptr is the last write.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(N)) begin
                idx = idx - (IW + 1)'(N);
            end
            if (req[idx[IW-1:0]]) begin
                winner  = idx[IW-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX among NUM_REQ byte streams; UART_ARB_TIMEOUT_EN adds a stalled-owner release.
// Grant 1 cycle after request, then zero-latency pass-through; tx_ready reaches only the owner, others see req_ready=0.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int            IW      = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] pick_id;
    logic          pick_any;
    logic          lock;
    logic          own_valid;
    logic          own_last;
    logic          xfer;
    logic [IW-1:0] next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .winner  (pick_id),
        .any_req (pick_any)
    );

    assign lock      = (state_q == ARB_LOCK);
    assign own_valid = req_valid[grant_id_q];
    assign own_last  = req_last[grant_id_q];
    assign xfer      = lock && own_valid && tx_ready;
    assign next_ptr  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (lock) begin
            req_ready[grant_id_q] = tx_ready;
        end
    end

    assign tx_valid = lock && own_valid;
    assign tx_data  = lock ? req_data[grant_id_q*DATA_W +: DATA_W] : '0;
    assign busy     = lock;
    assign grant_id = grant_id_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
    // Keeps TIMEOUT_CYCLES referenced so both builds share one parameter list.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_LOCK;
                    grant_id_d = pick_id;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            ARB_LOCK: begin
                if (xfer && own_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only consecutive cycles with the owner's valid low count as a stall.
                if (own_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == STALL_MAX) begin
                    state_d       = ARB_IDLE;
                    rr_ptr_d      = next_ptr;
                    timeout_err_d = 1'b1;
                    stall_cnt_d   = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic              tx_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    typedef struct {
        int         cyc;
        int         gid;
        logic [7:0] dat;
    } fire_t;

    ent_t  pq [N][$];
    fire_t flog[$];
    int    stall_left [N];
    bit    rdy_pat[$];
    bit    rand_rdy;
    bit    chk_en;
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    n_pop  = 0;
    logic  busy_hist [4096];
    int    gid_hist  [4096];
    logic  terr_hist [4096];

    // Reference model: owner (-1 when free), rotation pointer, last grant, stall run length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_gid   = 0;
    int m_stall = 0;
    bit m_terr  = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_fire(string nm, int idx, int ec, int eg, int ed);
        if (idx >= flog.size()) begin
            checks++;
            errors++;
            $display("FAIL %s transfer #%0d missing, only %0d seen", nm, idx, flog.size());
        end else begin
            chk({nm, "_cyc"}, flog[idx].cyc, ec);
            chk({nm, "_gid"}, flog[idx].gid, eg);
            chk({nm, "_dat"}, {24'd0, flog[idx].dat}, ed);
        end
    endtask

    task automatic send(int r, int n, int base);
        for (int k = 0; k < n; k++) begin
            pq[r].push_back('{d: 8'(base + k), l: (k == n - 1)});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (stall_left[i] > 0) begin
                req_valid[i] = 1'b0;
                stall_left[i]--;
            end else if (pq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pq[i][0].d;
                req_last[i]           = pq[i][0].l;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        if (rdy_pat.size() > 0) tx_ready = rdy_pat.pop_front();
        else if (rand_rdy)      tx_ready = ($urandom_range(3) != 0);
        else                    tx_ready = 1'b1;
    endtask

    task automatic check();
        logic         e_busy;
        logic         e_valid;
        logic [DW-1:0] e_data;
        logic [N-1:0] e_ready;
        e_busy  = (m_owner >= 0);
        e_valid = 1'b0;
        e_data  = '0;
        e_ready = '0;
        if (e_busy) begin
            e_valid = 1'((req_valid >> m_owner) & N'(1));
            e_data  = DW'(req_data >> (m_owner * DW));
            e_ready = N'(tx_ready) << m_owner;
        end
        if (cyc < 4096) begin
            busy_hist[cyc] = busy;
            gid_hist[cyc]  = int'(grant_id);
            terr_hist[cyc] = timeout_err;
        end
        if (tx_valid === 1'b1 && tx_ready) flog.push_back('{cyc, int'(grant_id), tx_data});
        if (chk_en) begin
            chk("busy",        {31'd0, busy},        {31'd0, e_busy});
            chk("tx_valid",    {31'd0, tx_valid},    {31'd0, e_valid});
            chk("tx_data",     {24'd0, tx_data},     {24'd0, e_data});
            chk("req_ready",   {29'd0, req_ready},   {29'd0, e_ready});
            chk("grant_id",    {30'd0, grant_id},    m_gid);
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
        end
    endtask

    task automatic update();
        int o;
        bit fire;
        o    = m_owner;
        fire = (o >= 0) && req_valid[o] && tx_ready;
        if (fire) begin
            void'(pq[o].pop_front());
            n_pop++;
        end
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_gid   = 0;
            m_stall = 0;
            m_terr  = 1'b0;
        end else begin
            m_terr = 1'b0;
            if (o < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                if (m_owner >= 0) begin
                    m_gid   = m_owner;
                    m_stall = 0;
                end
            end else if (fire) begin
                m_stall = 0;
                if (req_last[o]) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % N;
                end
            end else if (!req_valid[o]) begin
`ifdef UART_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % N;
                    m_terr  = 1'b1;
                    m_stall = 0;
                end
`endif
            end else begin
                m_stall = 0;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
        cyc++;
    endtask

    initial begin
        int c0;
        int fa;
        int bad;
        int guard;
        bit pending;

        rst       = 1'b1;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        rand_rdy  = 1'b0;
        chk_en    = 1'b0;
        for (int i = 0; i < N; i++) stall_left[i] = 0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_busy",      {31'd0, busy},        0);
        chk("rst_tx_valid",  {31'd0, tx_valid},    0);
        chk("rst_tx_data",   {24'd0, tx_data},     0);
        chk("rst_req_ready", {29'd0, req_ready},   0);
        chk("rst_grant_id",  {30'd0, grant_id},    0);
        chk("rst_timeout",   {31'd0, timeout_err}, 0);
        rst = 1'b0;

        // Single requester, three-byte packet.
        fa = flog.size();
        c0 = cyc;
        send(1, 3, 'hA1);
        repeat (6) step();
        chk("single_grant", gid_hist[c0+1], 1);
        chk_fire("single_b0", fa,     c0 + 1, 1, 'hA1);
        chk_fire("single_b1", fa + 1, c0 + 2, 1, 'hA2);
        chk_fire("single_b2", fa + 2, c0 + 3, 1, 'hA3);
        chk("single_busy_last", {31'd0, busy_hist[c0+3]}, 1);
        chk("single_busy_drop", {31'd0, busy_hist[c0+4]}, 0);

        // Contention from reset: rotation 0,1,2,0,1,2 with one idle cycle between grants.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fa = flog.size();
        c0 = cyc;
        for (int r = 0; r < N; r++) begin
            send(r, 1, 'h10 + r);
            send(r, 1, 'h20 + r);
        end
        repeat (14) step();
        for (int j = 0; j < 6; j++) begin
            chk_fire("rr", fa + j, c0 + 1 + 2 * j, j % 3, (j < 3) ? ('h10 + j) : ('h20 + j - 3));
        end

        // Backpressure during a two-byte packet while another requester waits.
        fa = flog.size();
        c0 = cyc;
        send(0, 2, 'hC0);
        send(1, 1, 'hD0);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        repeat (9) step();
        chk_fire("bp_b0",    fa,     c0 + 1, 0, 'hC0);
        chk_fire("bp_b1",    fa + 1, c0 + 4, 0, 'hC1);
        chk_fire("bp_other", fa + 2, c0 + 6, 1, 'hD0);

        // Owner stall: requester 0 drops valid for 10 cycles while requester 2 waits.
        fa = flog.size();
        c0 = cyc;
        send(0, 3, 'hB0);
        step();
        send(2, 1, 'hE2);
        step();
        stall_left[0] = 10;
        repeat (16) step();
        bad = 0;
        for (int c = c0 + 2; c < c0 + 12; c++) if (busy_hist[c] !== 1'b1 || gid_hist[c] != 0) bad++;
        chk("stall_lock_held", bad, 0);
        chk_fire("stall_b0",  fa,     c0 + 1,  0, 'hB0);
        chk_fire("stall_b1",  fa + 1, c0 + 12, 0, 'hB1);
        chk_fire("stall_b2",  fa + 2, c0 + 13, 0, 'hB2);
        chk_fire("stall_req2", fa + 3, c0 + 15, 2, 'hE2);

        // Reset mid-packet after moving the pointer away from 0.
        send(1, 1, 'h51);
        repeat (3) step();
        fa = flog.size();
        c0 = cyc;
        send(0, 4, 'h60);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pq[0].delete();
        chk("abort_tx_valid", {31'd0, tx_valid}, 0);
        chk("abort_busy",     {31'd0, busy},     0);
        chk("abort_grant_id", {30'd0, grant_id}, 0);
        for (int r = 0; r < N; r++) send(r, 1, 'h70 + r);
        repeat (8) step();
        chk_fire("abort_first", fa + 2, c0 + 4, 0, 'h70);

        // Owner stalls 20 cycles mid-packet with requester 1 waiting.
        fa = flog.size();
        c0 = cyc;
        send(0, 2, 'h80);
        send(1, 1, 'h90);
        step();
        step();
        stall_left[0] = 20;
        repeat (26) step();
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_pulse_early", {31'd0, terr_hist[c0+17]}, 0);
        chk("to_pulse",       {31'd0, terr_hist[c0+18]}, 1);
        chk("to_pulse_width", {31'd0, terr_hist[c0+19]}, 0);
        chk_fire("to_next", fa + 1, c0 + 19, 1, 'h90);
`else
        chk("hold_busy_20",  {31'd0, busy_hist[c0+21]}, 1);
        chk("hold_gid_20",   gid_hist[c0+21], 0);
        chk_fire("hold_b1",  fa + 1, c0 + 22, 0, 'h81);
        chk_fire("hold_req1", fa + 2, c0 + 24, 1, 'h90);
`endif

        // Randomized traffic, then drain.
        rand_rdy = 1'b1;
        repeat (700) begin
            if ($urandom_range(7) == 0) begin
                int r;
                r = int'($urandom_range(N - 1));
                if (pq[r].size() < 8) send(r, int'($urandom_range(4, 1)), int'($urandom_range(255)));
            end
            if ($urandom_range(31) == 0) stall_left[$urandom_range(N - 1)] = int'($urandom_range(3, 1));
            step();
        end
        rand_rdy = 1'b0;
        guard    = 0;
        pending  = 1'b1;
        while (pending && guard < 400) begin
            pending = 1'b0;
            for (int r = 0; r < N; r++) if (pq[r].size() > 0) pending = 1'b1;
            if (pending) begin
                step();
                guard++;
            end
        end
        chk("drain_done", {31'd0, pending}, 0);
        chk("fire_count", flog.size(), n_pop);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
